// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file for the dual-issue pipeline.
// NRD combinational read ports with write-through, NWR write ports, a
// jump-and-link write, a per-register busy scoreboard, and a post-reset
// scrub that zeroes one register per cycle before the file reports ready.
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int REG_NUM   = 32,
  parameter int ADDR_SIZE = 5,
  parameter int NRD       = 2,
  parameter int NWR       = 2,
  parameter int VPC_BITS  = 32,
  parameter int LINK_REG  = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NRD*ADDR_SIZE-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]      rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR*ADDR_SIZE-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0]      wr_data,
  input  logic                     jl_en,
  input  logic [VPC_BITS-1:0]      jl_pc,
  input  logic                     iss_en,
  input  logic [ADDR_SIZE-1:0]     iss_rd
);

  localparam logic [ADDR_SIZE-1:0] LINK_IDX = ADDR_SIZE'(LINK_REG);
  localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(REG_NUM - 1);

  typedef enum logic {
    SCRUB,
    READY
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [ADDR_SIZE-1:0]   idx_q;

  logic [XLEN-1:0]        regs [REG_NUM];
  logic [REG_NUM-1:0]     busy_q;

  logic [REG_NUM-1:0]     wr_hit;
  logic [XLEN-1:0]        wr_val [REG_NUM];
  logic                   link_conflict;
  logic                   jl_eff;
  logic [VPC_BITS-1:0]    link_sum;
  logic [XLEN-1:0]        link_val;

  // State register: reset always restarts the scrub from index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCRUB;
    end else begin
      state_q <= state_d;
    end
  end

  // Scrub index: advances once per cycle while scrubbing.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else if (state_q == SCRUB) begin
      idx_q <= idx_q + ADDR_SIZE'(1);
    end
  end

  // Next state: leave SCRUB on the edge that clears the last register.
  always_comb begin
    state_d = state_q;
    if (state_q == SCRUB && idx_q == LAST_IDX) begin
      state_d = READY;
    end
  end

  // Outputs of the FSM: ready follows the registered state.
  always_comb begin
    ready = (state_q == READY);
  end

  // Link value is the return address, resized to the data width.
  assign link_sum = jl_pc + VPC_BITS'(4);
  assign link_val = XLEN'(link_sum);

  // Write decode: ascending port order so the highest-index port wins.
  always_comb begin
    wr_hit        = '0;
    link_conflict = 1'b0;
    for (int r = 0; r < REG_NUM; r++) begin
      wr_val[r] = '0;
    end
    for (int p = 0; p < NWR; p++) begin
      if (ready && wr_en[p]) begin
        wr_hit[wr_addr[p*ADDR_SIZE +: ADDR_SIZE]] = 1'b1;
        wr_val[wr_addr[p*ADDR_SIZE +: ADDR_SIZE]] = wr_data[p*XLEN +: XLEN];
        if (wr_addr[p*ADDR_SIZE +: ADDR_SIZE] == LINK_IDX) begin
          link_conflict = 1'b1;
        end
      end
    end
  end

  assign jl_eff = ready & jl_en & ~link_conflict;

  // Storage: scrub zeroing, then port writes with the link write as fallback.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs[0] <= '0;
    end else if (state_q == SCRUB) begin
      regs[idx_q] <= '0;
    end else begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end else if (jl_eff && ADDR_SIZE'(r) == LINK_IDX) begin
          regs[r] <= link_val;
        end
      end
    end
  end

  // Busy scoreboard: an issue sets, a completing write clears, set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else if (state_q == READY) begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (iss_en && iss_rd == ADDR_SIZE'(r)) begin
          busy_q[r] <= 1'b1;
        end else if (wr_hit[r] || (jl_eff && ADDR_SIZE'(r) == LINK_IDX)) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  // Read ports: zero until ready and for x0, otherwise write-through first.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_SIZE-1:0] addr;
    logic                 link_hit;
    logic                 through;
    logic                 valid;

    assign addr     = rd_addr[p*ADDR_SIZE +: ADDR_SIZE];
    assign link_hit = jl_eff & (addr == LINK_IDX);
    assign through  = wr_hit[addr] | link_hit;
    assign valid    = ready & (addr != '0);

    assign rd_data[p*XLEN +: XLEN] = !valid       ? '0 :
                                     wr_hit[addr] ? wr_val[addr] :
                                     link_hit     ? link_val :
                                                    regs[addr];
    assign rd_busy[p] = valid & busy_q[addr] & ~through;
  end

endmodule
